lane_game_sequencer: RTL and testbench

Per-frame game sequencer for the runner display pipeline. Generalises the top-level countdown / logo fade-out / player fade-in / play flow into a parametrised block with N lanes. It adds edge-triggered lane stepping, pause/resume, per-lane coin-spawn enables and a saturating score counter. It runs entirely in the pixel-fabric clock domain, advances only on a one-cycle frame tick, and drives the offset/flip/enable inputs of the spawn and layer blocks.

---
 rtl/lane_game_sequencer_if.sv | 41 ++++
 rtl/lane_game_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lane_game_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_game_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_game_sequencer_if : frame/button/coin inputs and display outputs    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface lane_game_sequencer_if #(
  parameter int W          = 12,
  parameter int LANES      = 3,
  parameter int SPAWN_BITS = 3,
  parameter int SCORE_W    = 16
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                      frame_tick;
  logic                      btn_left;
  logic                      btn_right;
  logic                      btn_pause;
  logic [LANES*SPAWN_BITS:0] random;
  logic [LANES-1:0]          coin_hit;
  logic [2:0]                state;
  logic [W-1:0]              logo_voffset;
  logic [W-1:0]              head_hoffset;
  logic [W-1:0]              head_voffset;
  logic [LW-1:0]             lane;
  logic [LANES-1:0]          spawn_en;
  logic                      coin_flip;
  logic [SCORE_W-1:0]        score;

  modport master (
    output frame_tick, btn_left, btn_right, btn_pause, random, coin_hit,
    input  state, logo_voffset, head_hoffset, head_voffset, lane, spawn_en,
           coin_flip, score
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_pause, random, coin_hit,
    output state, logo_voffset, head_hoffset, head_voffset, lane, spawn_en,
           coin_flip, score
  );
endinterface
`default_nettype wire

// File: rtl/lane_game_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_game_sequencer : countdown/logo/intro/play sequencer with N lanes   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lane_game_sequencer #(
  parameter int W          = 12,
  parameter int LANES      = 3,
  parameter int LANE_PITCH = 100,
  parameter int COUNTDOWN  = 5,
  parameter int LOGO_STEP  = 30,
  parameter int LOGO_END   = 640,
  parameter int HEAD_START = 180,
  parameter int HEAD_STEP  = 20,
  parameter int HEAD_END   = 50,
  parameter int SPAWN_BITS = 3,
  parameter int SCORE_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lane_game_sequencer_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (COUNTDOWN > 0) ? $clog2(COUNTDOWN + 1) : 1;
  localparam logic [LW-1:0] c_lane_ctr   = LW'((LANES - 1) / 2);
  localparam logic [LW-1:0] c_lane_max   = LW'(LANES - 1);
  localparam logic [W-1:0]  c_logo_end   = W'(LOGO_END);
  localparam logic [W-1:0]  c_logo_step  = W'(LOGO_STEP);
  localparam logic [W-1:0]  c_head_start = W'(HEAD_START);
  localparam logic [W-1:0]  c_head_end   = W'(HEAD_END);
  localparam logic [W-1:0]  c_head_step  = W'(HEAD_STEP);
  localparam logic [CW-1:0] c_count      = CW'(COUNTDOWN);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_COUNT = 3'd1,
    ST_LOGO  = 3'd2,
    ST_INTRO = 3'd3,
    ST_PLAY  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [W-1:0]       r_logo;
  logic [W-1:0]       r_head_v;
  logic [W-1:0]       r_head_h;
  logic [LW-1:0]      r_lane;
  logic [LANES-1:0]   r_spawn;
  logic               r_flip;
  logic [SCORE_W-1:0] r_score;
  logic               r_btn_l_q, r_btn_r_q, r_btn_p_q;
  logic               r_pend_l, r_pend_r, r_pend_p;

  logic               w_go_l, w_go_r, w_go_p;
  logic               w_hit;
  logic [LW-1:0]      w_lane_nxt;
  logic [W-1:0]       w_hoff_nxt;
  logic [LANES-1:0]   w_spawn;

  // An edge landing on the tick cycle itself is folded in rather than lost.
  assign w_go_l = r_pend_l | (bus.btn_left  & ~r_btn_l_q);
  assign w_go_r = r_pend_r | (bus.btn_right & ~r_btn_r_q);
  assign w_go_p = r_pend_p | (bus.btn_pause & ~r_btn_p_q);
  assign w_hit  = (r_state == ST_PLAY) && bus.coin_hit[r_lane];

  always_comb begin
    w_lane_nxt = r_lane;
    if (w_go_l && !w_go_r && r_lane != '0)
      w_lane_nxt = r_lane - 1'b1;
    else if (w_go_r && !w_go_l && r_lane != c_lane_max)
      w_lane_nxt = r_lane + 1'b1;
    w_hoff_nxt = W'((int'(w_lane_nxt) - int'(c_lane_ctr)) * LANE_PITCH);
    w_spawn = '0;
    for (int i = 0; i < LANES; i++)
      w_spawn[i] = &bus.random[i*SPAWN_BITS +: SPAWN_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_count   <= c_count;
      r_logo    <= '0;
      r_head_v  <= c_head_start;
      r_head_h  <= '0;
      r_lane    <= c_lane_ctr;
      r_spawn   <= '0;
      r_flip    <= 1'b0;
      r_score   <= '0;
      r_btn_l_q <= 1'b0;
      r_btn_r_q <= 1'b0;
      r_btn_p_q <= 1'b0;
      r_pend_l  <= 1'b0;
      r_pend_r  <= 1'b0;
      r_pend_p  <= 1'b0;
    end else begin
      r_btn_l_q <= bus.btn_left;
      r_btn_r_q <= bus.btn_right;
      r_btn_p_q <= bus.btn_pause;
      r_pend_l  <= w_go_l & ~bus.frame_tick;
      r_pend_r  <= w_go_r & ~bus.frame_tick;
      r_pend_p  <= w_go_p & ~bus.frame_tick;
      if (w_hit && r_score != '1)
        r_score <= r_score + 1'b1;
      if (bus.frame_tick) begin
        case (r_state)
          ST_RESET: begin
            r_state  <= ST_COUNT;
            r_count  <= c_count;
            r_logo   <= '0;
            r_head_v <= c_head_start;
            r_head_h <= '0;
            r_lane   <= c_lane_ctr;
            r_spawn  <= '0;
            r_flip   <= 1'b0;
            r_score  <= '0;
          end
          ST_COUNT: begin
            if (r_count != '0) r_count <= r_count - 1'b1;
            else               r_state <= ST_LOGO;
          end
          ST_LOGO: begin
            if (r_logo == c_logo_end)
              r_state <= ST_INTRO;
            else if (r_logo > c_logo_end - c_logo_step)
              r_logo <= c_logo_end;
            else
              r_logo <= r_logo + c_logo_step;
          end
          ST_INTRO: begin
            if (r_head_v == c_head_end)
              r_state <= ST_PLAY;
            else if (r_head_v < c_head_end + c_head_step)
              r_head_v <= c_head_end;
            else
              r_head_v <= r_head_v - c_head_step;
          end
          ST_PLAY: begin
            // Pause wins over any lane move pending on the same tick.
            if (w_go_p) begin
              r_state <= ST_PAUSE;
              r_spawn <= '0;
            end else begin
              r_spawn  <= w_spawn;
              r_flip   <= bus.random[LANES*SPAWN_BITS];
              r_lane   <= w_lane_nxt;
              r_head_h <= w_hoff_nxt;
            end
          end
          ST_PAUSE: begin
            r_spawn <= '0;
            if (w_go_p) r_state <= ST_PLAY;
          end
          default: r_state <= ST_RESET;
        endcase
      end
    end
  end

  assign bus.state        = r_state;
  assign bus.logo_voffset = r_logo;
  assign bus.head_hoffset = r_head_h;
  assign bus.head_voffset = r_head_v;
  assign bus.lane         = r_lane;
  assign bus.spawn_en     = r_spawn;
  assign bus.coin_flip    = r_flip;
  assign bus.score        = r_score;
endmodule
`default_nettype wire

// File: tb/tb_lane_game_sequencer.sv
`default_nettype none
// Bench for lane_game_sequencer: random stimulus against a tick-count /
// game-rule model; a second instance with a 4-bit score covers saturation.
module tb_lane_game_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_game_sequencer_if #(.W(12), .LANES(3), .SPAWN_BITS(3), .SCORE_W(16)) ifc ();
  lane_game_sequencer_if #(.W(12), .LANES(3), .SPAWN_BITS(3), .SCORE_W(4))  ifc2 ();

  assign ifc2.frame_tick = ifc.frame_tick;
  assign ifc2.btn_left   = ifc.btn_left;
  assign ifc2.btn_right  = ifc.btn_right;
  assign ifc2.btn_pause  = ifc.btn_pause;
  assign ifc2.random     = ifc.random;
  assign ifc2.coin_hit   = ifc.coin_hit;

  lane_game_sequencer #(.W(12), .LANES(3), .SCORE_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc));
  lane_game_sequencer #(.W(12), .LANES(3), .SCORE_W(4))  dut_s (.clk(clk), .rst(rst), .bus(ifc2));

  int total = 0;
  int bad   = 0;

  // Model: startup phase is a pure function of the tick count; play is game rules.
  int         m_n, m_logo, m_head, m_lane, m_score, m_score2;
  logic [2:0] m_state, m_spawn;
  logic       m_flip;
  bit         m_pl, m_pr, m_pp;

  task automatic m_reset();
    m_n = 0; m_state = 3'd0; m_logo = 0; m_head = 180; m_lane = 1;
    m_spawn = '0; m_flip = 1'b0; m_score = 0; m_score2 = 0;
    m_pl = 0; m_pr = 0; m_pp = 0;
  endtask

  task automatic m_tick(input logic [9:0] rnd);
    if (m_state == 3'd4 || m_state == 3'd5) begin
      if (m_pp) begin
        m_state = (m_state == 3'd4) ? 3'd5 : 3'd4;
        m_spawn = '0;
      end else if (m_state == 3'd4) begin
        for (int i = 0; i < 3; i++) m_spawn[i] = (rnd[i*3 +: 3] == 3'b111);
        m_flip = rnd[9];
        m_lane = m_lane + int'(m_pr) - int'(m_pl);
        if (m_lane < 0) m_lane = 0;
        if (m_lane > 2) m_lane = 2;
      end
    end else begin
      m_n++;
      m_state = (m_n >= 38) ? 3'd4 : (m_n >= 30) ? 3'd3 : (m_n >= 7) ? 3'd2 : 3'd1;
      m_logo  = (m_n < 8) ? 0 : ((30 * (m_n - 7) > 640) ? 640 : 30 * (m_n - 7));
      m_head  = (m_n < 31) ? 180 : ((180 - 20 * (m_n - 30) < 50) ? 50 : 180 - 20 * (m_n - 30));
    end
    m_pl = 0; m_pr = 0; m_pp = 0;
  endtask

  task automatic tick(input logic [9:0] rnd);
    @(negedge clk); ifc.frame_tick = 1'b1; ifc.random = rnd;
    @(negedge clk); ifc.frame_tick = 1'b0;
    m_tick(rnd);
  endtask

  task automatic burst(input int n, input logic [9:0] rnd);
    @(negedge clk); ifc.frame_tick = 1'b1; ifc.random = rnd;
    repeat (n) @(negedge clk);
    ifc.frame_tick = 1'b0;
    repeat (n) m_tick(rnd);
  endtask

  task automatic press(input bit l, input bit r, input bit p);
    @(negedge clk); ifc.btn_left = l; ifc.btn_right = r; ifc.btn_pause = p;
    @(negedge clk); ifc.btn_left = 1'b0; ifc.btn_right = 1'b0; ifc.btn_pause = 1'b0;
    m_pl = m_pl | l; m_pr = m_pr | r; m_pp = m_pp | p;
  endtask

  task automatic hit(input logic [2:0] mask, input int cycles);
    @(negedge clk); ifc.coin_hit = mask;
    repeat (cycles) begin
      @(negedge clk);
      if (m_state == 3'd4 && mask[m_lane]) begin
        if (m_score < 65535) m_score++;
        if (m_score2 < 15) m_score2++;
      end
    end
    ifc.coin_hit = '0;
  endtask

  task automatic test_reset();
    total++; if (ifc.state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", ifc.state); end
    total++; if (ifc.logo_voffset !== 12'd0) begin bad++; $display("FAIL reset_logo got %0d want 0", ifc.logo_voffset); end
    total++; if (ifc.head_voffset !== 12'd180) begin bad++; $display("FAIL reset_head_v got %0d want 180", ifc.head_voffset); end
    total++; if (ifc.lane !== 2'd1) begin bad++; $display("FAIL reset_lane got %0d want 1", ifc.lane); end
    total++; if (ifc.head_hoffset !== 12'd0) begin bad++; $display("FAIL reset_head_h got %h want 000", ifc.head_hoffset); end
    total++; if (ifc.spawn_en !== 3'b000) begin bad++; $display("FAIL reset_spawn got %b want 000", ifc.spawn_en); end
    total++; if (ifc.coin_flip !== 1'b0) begin bad++; $display("FAIL reset_flip got %b want 0", ifc.coin_flip); end
    total++; if (ifc.score !== 16'd0) begin bad++; $display("FAIL reset_score got %0d want 0", ifc.score); end
  endtask

  task automatic test_startup();
    int first_play = -1;
    for (int t = 1; t <= 40; t++) begin
      tick(10'($urandom));
      total++; if (ifc.state !== m_state) begin bad++; $display("FAIL start_state t%0d got %0d want %0d", t, ifc.state, m_state); end
      total++; if (ifc.logo_voffset !== 12'(m_logo)) begin bad++; $display("FAIL start_logo t%0d got %0d want %0d", t, ifc.logo_voffset, m_logo); end
      total++; if (ifc.head_voffset !== 12'(m_head)) begin bad++; $display("FAIL start_head t%0d got %0d want %0d", t, ifc.head_voffset, m_head); end
      total++; if (ifc.spawn_en !== m_spawn) begin bad++; $display("FAIL start_spawn t%0d got %b want %b", t, ifc.spawn_en, m_spawn); end
      total++; if (ifc.logo_voffset > 12'd640) begin bad++; $display("FAIL start_logo_max t%0d got %0d want <=640", t, ifc.logo_voffset); end
      if (first_play < 0 && ifc.state == 3'd4) first_play = t;
    end
    total++; if (first_play != 38) begin bad++; $display("FAIL play_entry got tick %0d want 38", first_play); end
  endtask

  task automatic test_lane_moves();
    for (int k = 0; k < 3; k++) begin
      press(1, 0, 0);
      tick(10'($urandom));
      total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL left_lane k%0d got %0d want %0d", k, ifc.lane, m_lane); end
      total++; if (ifc.head_hoffset !== 12'((m_lane - 1) * 100)) begin bad++; $display("FAIL left_hoff k%0d got %h want %h", k, ifc.head_hoffset, 12'((m_lane - 1) * 100)); end
      total++; if (ifc.spawn_en !== m_spawn || ifc.coin_flip !== m_flip) begin bad++; $display("FAIL play_spawn k%0d got %b/%b want %b/%b", k, ifc.spawn_en, ifc.coin_flip, m_spawn, m_flip); end
    end
    total++; if (ifc.head_hoffset !== 12'hF9C) begin bad++; $display("FAIL left_sat_hoff got %h want f9c", ifc.head_hoffset); end
    press(0, 1, 0);
    tick(10'($urandom));
    total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL right_lane got %0d want %0d", ifc.lane, m_lane); end
    total++; if (ifc.head_hoffset !== 12'((m_lane - 1) * 100)) begin bad++; $display("FAIL right_hoff got %h want %h", ifc.head_hoffset, 12'((m_lane - 1) * 100)); end
  endtask

  task automatic test_both_buttons();
    press(1, 1, 0);
    tick(10'($urandom));
    total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL both_lane got %0d want %0d", ifc.lane, m_lane); end
    tick(10'($urandom));
    total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL both_next_lane got %0d want %0d", ifc.lane, m_lane); end
  endtask

  task automatic test_spawn_score();
    press(0, 1, 0);
    tick(10'($urandom));
    tick(10'b1_111_000_101);
    total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL spawn_lane got %0d want %0d", ifc.lane, m_lane); end
    total++; if (ifc.spawn_en !== m_spawn) begin bad++; $display("FAIL spawn_pattern got %b want %b", ifc.spawn_en, m_spawn); end
    total++; if (ifc.coin_flip !== m_flip) begin bad++; $display("FAIL spawn_flip got %b want %b", ifc.coin_flip, m_flip); end
    hit(3'b100, 2);
    total++; if (ifc.score !== 16'(m_score)) begin bad++; $display("FAIL score_hit got %0d want %0d", ifc.score, m_score); end
    hit(3'b001, 1);
    total++; if (ifc.score !== 16'(m_score)) begin bad++; $display("FAIL score_other_lane got %0d want %0d", ifc.score, m_score); end
    total++; if (ifc2.score !== 4'(m_score2)) begin bad++; $display("FAIL score_small got %0d want %0d", ifc2.score, m_score2); end
  endtask

  task automatic test_pause();
    press(0, 1, 1);
    tick(10'h3FF);
    total++; if (ifc.state !== m_state) begin bad++; $display("FAIL pause_state got %0d want %0d", ifc.state, m_state); end
    total++; if (ifc.lane !== 2'(m_lane)) begin bad++; $display("FAIL pause_lane got %0d want %0d", ifc.lane, m_lane); end
    total++; if (ifc.spawn_en !== m_spawn) begin bad++; $display("FAIL pause_spawn got %b want %b", ifc.spawn_en, m_spawn); end
    hit(3'b111, 2);
    total++; if (ifc.score !== 16'(m_score)) begin bad++; $display("FAIL pause_score got %0d want %0d", ifc.score, m_score); end
    press(1, 0, 0);
    tick(10'h3FF);
    total++; if (ifc.lane !== 2'(m_lane) || ifc.spawn_en !== m_spawn) begin bad++; $display("FAIL paused_move got %0d/%b want %0d/%b", ifc.lane, ifc.spawn_en, m_lane, m_spawn); end
    press(0, 0, 1);
    tick(10'($urandom));
    total++; if (ifc.state !== m_state) begin bad++; $display("FAIL resume_state got %0d want %0d", ifc.state, m_state); end
  endtask

  task automatic test_rst_mid();
    burst(17, 10'($urandom));
    total++; if (ifc.state !== m_state || ifc.logo_voffset !== 12'(m_logo)) begin bad++; $display("FAIL burst_logo got %0d/%0d want %0d/%0d", ifc.state, ifc.logo_voffset, m_state, m_logo); end
    @(negedge clk); #2; rst = 1'b1; #1;
    m_reset();
    total++; if (ifc.state !== m_state || ifc.logo_voffset !== 12'(m_logo) || ifc.head_voffset !== 12'(m_head)) begin bad++; $display("FAIL async_rst_seq got %0d/%0d/%0d want 0/0/180", ifc.state, ifc.logo_voffset, ifc.head_voffset); end
    total++; if (ifc.lane !== 2'd1 || ifc.head_hoffset !== 12'd0 || ifc.spawn_en !== 3'd0 || ifc.coin_flip !== 1'b0 || ifc.score !== 16'd0) begin bad++; $display("FAIL async_rst_play got lane%0d h%h s%b f%b sc%0d want reset values", ifc.lane, ifc.head_hoffset, ifc.spawn_en, ifc.coin_flip, ifc.score); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    tick(10'($urandom));
    total++; if (ifc.state !== m_state) begin bad++; $display("FAIL restart_state got %0d want %0d", ifc.state, m_state); end
  endtask

  task automatic test_saturation();
    burst(37, 10'($urandom));
    total++; if (ifc.state !== m_state) begin bad++; $display("FAIL sat_play got %0d want %0d", ifc.state, m_state); end
    hit(3'b010, 20);
    total++; if (ifc.score !== 16'(m_score)) begin bad++; $display("FAIL sat_score16 got %0d want %0d", ifc.score, m_score); end
    total++; if (ifc2.score !== 4'(m_score2)) begin bad++; $display("FAIL sat_score4 got %0d want %0d", ifc2.score, m_score2); end
    hit(3'b010, 3);
    total++; if (ifc2.score !== 4'hF) begin bad++; $display("FAIL sat_hold got %h want f", ifc2.score); end
  endtask

  initial begin
    ifc.frame_tick = 1'b0; ifc.btn_left = 1'b0; ifc.btn_right = 1'b0; ifc.btn_pause = 1'b0;
    ifc.random = '0; ifc.coin_hit = '0;
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_startup();
    test_lane_moves();
    test_both_buttons();
    test_spawn_score();
    test_pause();
    test_rst_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
